mac_seq_divider: RTL and testbench
==================================

// Module: mac_seq_divider
// PURPOSE
//   Sequential restoring divider that inverts the MAC datapath.
//   It divides a DW-bit accumulated value (MAC y output width) by a VW-bit operand (MAC a/b operand width).
//   It produces one quotient bit per clock and uses a start/busy/done handshake.
//   It sits downstream of the MAC to normalise or average accumulated results.
// PARAMETERS
//   DW  10  dividend and quotient width (matches MAC accumulator width)
//   VW  4   divisor and remainder width (matches MAC operand width)
// PORTS
//   clk        input   1   rising-edge clock
//   rst        input   1   asynchronous, active-low reset
//   start      input   1   request; sampled on rising edge when ready
//   dividend   input   DW  unsigned dividend; sampled with start
//   divisor    input   VW  unsigned divisor; sampled with start
//   busy       output  1   division in progress
//   done       output  1   one-cycle pulse; results valid
//   quotient   output  DW  unsigned quotient; held until next accept
//   remainder  output  VW  unsigned remainder; held until next accept
//   div_by_zero output 1   set with done when sampled divisor==0; held
// BEHAVIOUR
// - Reset (rst=0, async):
//   - state=IDLE.
//   - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
//   - Internal counter and partial remainder are cleared.
//   - Reset asserted mid-division aborts it; no done pulse is produced.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE: start=1 at edge E0 accepts the request.
//     - Latches dividend and divisor.
//     - Clears the partial remainder (VW+1 bits) and sets count=DW-1.
//     - Next state is RUN; busy=1 from E0.
//   - RUN: one restoring step per edge, MSB of dividend first.
//     - pr = {pr[VW-1:0], dvd[count]}.
//     - If pr >= {0,divisor}: pr -= divisor and q[count]=1; else q[count]=0.
//     - After the step with count=0 (edge E_DW), the next state is DONE.
//     - At E_DW, quotient and remainder registers are loaded.
//     - Also at E_DW: busy=0, done=1.
//   - DONE: lasts exactly one cycle (done=1). Next state is IDLE.
//     - Exception: if start=1 in this cycle, the new request is accepted as in IDLE.
//     - Back-to-back requests therefore lose no cycle.
// - Latency:
//   - Accept edge E0 to done high: DW clock edges (10 by default).
//   - Throughput: one division per DW+1 cycles with start held high.
// - Divide by zero (divisor==0 at accept):
//   - RUN is skipped. At E1: state=DONE, done=1, busy=0.
//   - quotient={DW{1}}, remainder=0, div_by_zero=1.
// - div_by_zero is cleared on the next accepted start.
// - start while busy=1 is ignored; dividend/divisor changes while busy have no effect.
// - Outputs are purely registered; no combinational path from inputs to outputs.
// - Arithmetic: remainder < divisor always fits VW bits.
//   - Internal pr is VW+1 bits so the compare/subtract never overflows.
// TESTING
// - rst=0 for 100ns, then release -> all outputs 0, busy=0, done=0.
// - 100/7 -> quotient=14, remainder=2, div_by_zero=0.
//   - done pulses exactly 10 edges after accept; busy high for those 10 cycles.
// - 1023/15 -> quotient=68, remainder=3. 10/5 (MAC 2*5 result) -> quotient=2, remainder=0.
//   - 3/9 -> quotient=0, remainder=3.
// - 5/0 -> done 1 edge after accept, quotient=1023, remainder=0, div_by_zero=1.
//   - A following 20/4 -> quotient=5, remainder=0, div_by_zero=0.
// - start pulsed again at cycle 4 of a 100/7 run, with different operands:
//   - Expect it ignored; result 14 r 2.
//   - start held high through done: second division accepted in the done cycle, no idle gap.
// - rst driven low mid-RUN (cycle 5) -> outputs immediately 0, no done pulse.
//   - After release, a fresh 100/7 completes correctly.

Source files
------------

// File: rtl/mac_seq_divider.sv
// Sequential restoring divider for MAC accumulator results: DW-bit dividend / VW-bit divisor,
// one quotient bit per clock, start/busy/done handshake with registered outputs.
module mac_seq_divider #(
    parameter int DW = 10,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [VW:0]   pr;
    logic [DW-1:0] q;
    logic [CW-1:0] count;

    logic          accept, dz, last, ge;
    logic [VW:0]   pr_sh, pr_nxt;
    logic [DW-1:0] q_nxt;

    // A new request is taken in IDLE and in the DONE cycle, so back-to-back runs lose no cycle.
    assign accept = start && (state != RUN);
    assign dz     = (dvs == '0);
    assign last   = (count == '0);

    // One restoring step; pr is one bit wider than the divisor so the compare never overflows.
    assign pr_sh  = {pr[VW-1:0], dvd[count]};
    assign ge     = (pr_sh >= {1'b0, dvs});
    assign pr_nxt = ge ? (pr_sh - {1'b0, dvs}) : pr_sh;
    assign q_nxt  = {q[DW-2:0], ge};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (dz || last) state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd         <= '0;
            dvs         <= '0;
            pr          <= '0;
            q           <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvd         <= dividend;
            dvs         <= divisor;
            pr          <= '0;
            q           <= '0;
            count       <= CW'(DW - 1);
            busy        <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (state == RUN) begin
            if (dz) begin
                busy        <= 1'b0;
                done        <= 1'b1;
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end else begin
                pr    <= pr_nxt;
                q     <= q_nxt;
                count <= count - CW'(1);
                if (last) begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    quotient  <= q_nxt;
                    remainder <= pr_nxt[VW-1:0];
                end
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_seq_divider.sv
// Directed checks for mac_seq_divider: reset, nominal divides, divide by zero,
// ignored start while busy, back-to-back requests and reset mid-run.
module tb_mac_seq_divider;

    localparam int DW = 10;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;

    int total = 0;
    int fails = 0;

    mac_seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done after an accept; returns edges waited and busy-high samples seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic do_div(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input int eq, input int er, input int edz, input int elat);
        int lat, bcnt;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy@accept"}, 32'(busy), 32'd1);
        wait_done(lat, bcnt);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " busy cycles"}, 32'(bcnt), 32'(elat));
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
        check({tag, " busy@done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " done one cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, bcnt, seen;

        // Reset held 100 ns, then released
        #100;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset dbz", 32'(div_by_zero), 32'd0);

        do_div("100/7",  10'd100,  4'd7,  14,   2, 0, 10);
        do_div("1023/15", 10'd1023, 4'd15, 68,  3, 0, 10);
        do_div("10/5",   10'd10,   4'd5,  2,    0, 0, 10);
        do_div("3/9",    10'd3,    4'd9,  0,    3, 0, 10);
        do_div("5/0",    10'd5,    4'd0,  1023, 0, 1, 1);
        do_div("20/4",   10'd20,   4'd4,  5,    0, 0, 10);

        // start re-pulsed with other operands mid-run is ignored
        @(negedge clk); start = 1'b1; dividend = 10'd100; divisor = 4'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); start = 1'b1; dividend = 10'd50; divisor = 4'd3;
        @(negedge clk); start = 1'b0;
        #1;
        wait_done(lat, bcnt);
        check("ignored start latency", 32'(lat + 4), 32'd10);
        check("ignored start quotient", 32'(quotient), 32'd14);
        check("ignored start remainder", 32'(remainder), 32'd2);
        @(posedge clk); #1;

        // start held through done: second request accepted in the done cycle
        @(negedge clk); start = 1'b1; dividend = 10'd100; divisor = 4'd7;
        @(posedge clk); #1;
        wait_done(lat, bcnt);
        check("b2b first latency", 32'(lat), 32'd10);
        check("b2b first quotient", 32'(quotient), 32'd14);
        dividend = 10'd1023; divisor = 4'd15;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b no gap busy", 32'(busy), 32'd1);
        check("b2b no gap done", 32'(done), 32'd0);
        wait_done(lat, bcnt);
        check("b2b second latency", 32'(lat), 32'd10);
        check("b2b second quotient", 32'(quotient), 32'd68);
        check("b2b second remainder", 32'(remainder), 32'd3);
        @(posedge clk); #1;

        // reset mid-run aborts without a done pulse
        @(negedge clk); start = 1'b1; dividend = 10'd100; divisor = 4'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst quotient", 32'(quotient), 32'd0);
        check("midrst remainder", 32'(remainder), 32'd0);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        @(negedge clk); rst = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("midrst no done pulse", 32'(seen), 32'd0);
        do_div("post-reset 100/7", 10'd100, 4'd7, 14, 2, 0, 10);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
